// File: rtl/bmp_header_parse.sv
// bmp_header_parse: parses the fixed-size header of a 24bpp BMP byte stream,
// exposes the image geometry fields, skips any gap up to the pixel array and
// forwards the pixel-array bytes one cycle after they are accepted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     incoming file bytes in file order
//   out_valid, out_data   forwarded pixel bytes (BGR, file order), registered
//   hdr_done              level, header fields valid until frame end
//   img_width, img_height low DIM_WIDTH bits of the header dimensions
//   bpp, data_offset      bits-per-pixel and pixel-array offset fields
//   hdr_err               level, header rejected (held until in_valid drops)
//   frame_done            one-cycle pulse once the pixel region is consumed
//
// Build option
//   BMP_PAD_STRIP_EN      when defined, row padding bytes are consumed but
//                         not forwarded; when undefined every pixel byte is.
module bmp_header_parse #(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned HDR_SIZE   = 54,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [BYTE_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  hdr_done,
    output logic [DIM_WIDTH-1:0]  img_width,
    output logic [DIM_WIDTH-1:0]  img_height,
    output logic [15:0]           bpp,
    output logic [31:0]           data_offset,
    output logic                  hdr_err,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        SKIP,
        PIXEL,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] height_q;
    logic [CNT_W-1:0] offset_q;
    logic [CNT_W-1:0] row_bytes_q;
    logic [CNT_W-1:0] pixel_total_q;
    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [7:0]       sig0_q;
    logic [7:0]       sig1_q;
    logic [15:0]      bpp_q;

    logic [7:0]       byte_c;
    logic [15:0]      bpp_now_c;
    logic             hdr_ok_c;
    logic [CNT_W-1:0] row_bytes_c;
    logic [CNT_W-1:0] pixel_total_c;
    logic             fwd_c;

    assign byte_c = in_data[7:0];

    // bpp high byte arrives on the same cycle as the sanity check
    assign bpp_now_c = {byte_c, bpp_q[7:0]};
    assign hdr_ok_c  = (sig0_q == 8'h42) && (sig1_q == 8'h4D) &&
                       (bpp_now_c == 16'd24) &&
                       (width_q != '0) && (height_q != '0);

    // Rows are padded to a 4-byte multiple
    assign row_bytes_c   = ((width_q * 32'd3 + 32'd3) >> 2) << 2;
    assign pixel_total_c = row_bytes_c * height_q;

`ifdef BMP_PAD_STRIP_EN
    logic [CNT_W-1:0] pad_q;
    logic [CNT_W-1:0] pad_c;

    assign pad_c = row_bytes_c - width_q * 32'd3;
    // Columns at or beyond the real pixel bytes of a row are padding
    assign fwd_c = (col_q < (row_bytes_q - pad_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_q <= '0;
        end else if (state == HEADER && in_valid && byte_cnt == 32'd29) begin
            pad_q <= pad_c;
        end
    end
`else
    assign fwd_c = 1'b1;
`endif

    assign img_width   = DIM_WIDTH'(width_q);
    assign img_height  = DIM_WIDTH'(height_q);
    assign bpp         = bpp_q;
    assign data_offset = offset_q;

    // Frame FSM with field capture, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            width_q       <= '0;
            height_q      <= '0;
            offset_q      <= '0;
            row_bytes_q   <= '0;
            pixel_total_q <= '0;
            col_q         <= '0;
            pix_cnt_q     <= '0;
            sig0_q        <= '0;
            sig1_q        <= '0;
            bpp_q         <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            hdr_done      <= 1'b0;
            hdr_err       <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sig0_q    <= byte_c;
                        byte_cnt  <= 32'd1;
                        col_q     <= '0;
                        pix_cnt_q <= '0;
                        state     <= HEADER;
                    end
                end

                HEADER: begin
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        case (byte_cnt)
                            32'd1:  sig1_q          <= byte_c;
                            32'd10: offset_q[7:0]   <= byte_c;
                            32'd11: offset_q[15:8]  <= byte_c;
                            32'd12: offset_q[23:16] <= byte_c;
                            32'd13: offset_q[31:24] <= byte_c;
                            32'd18: width_q[7:0]    <= byte_c;
                            32'd19: width_q[15:8]   <= byte_c;
                            32'd20: width_q[23:16]  <= byte_c;
                            32'd21: width_q[31:24]  <= byte_c;
                            32'd22: height_q[7:0]   <= byte_c;
                            32'd23: height_q[15:8]  <= byte_c;
                            32'd24: height_q[23:16] <= byte_c;
                            32'd25: height_q[31:24] <= byte_c;
                            32'd28: bpp_q[7:0]      <= byte_c;
                            32'd29: bpp_q[15:8]     <= byte_c;
                            default: ;
                        endcase

                        if (byte_cnt == 32'd29) begin
                            row_bytes_q   <= row_bytes_c;
                            pixel_total_q <= pixel_total_c;
                            if (!hdr_ok_c) begin
                                hdr_err <= 1'b1;
                                state   <= ERROR;
                            end
                        end

                        if (byte_cnt == 32'(HDR_SIZE - 1)) begin
                            hdr_done <= 1'b1;
                            if (offset_q > 32'(HDR_SIZE)) begin
                                state <= SKIP;
                            end else if (offset_q == 32'(HDR_SIZE)) begin
                                state <= PIXEL;
                            end else begin
                                hdr_err <= 1'b1;
                                state   <= ERROR;
                            end
                        end
                    end
                end

                SKIP: begin
                    if (in_valid) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        if (byte_cnt == offset_q - 32'd1) begin
                            state <= PIXEL;
                        end
                    end
                end

                PIXEL: begin
                    if (in_valid) begin
                        byte_cnt  <= byte_cnt + 32'd1;
                        pix_cnt_q <= pix_cnt_q + 32'd1;
                        if (fwd_c) begin
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                        end
                        col_q <= (col_q == row_bytes_q - 32'd1) ? '0 : col_q + 32'd1;
                        if (pix_cnt_q == pixel_total_q - 32'd1) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                // in_valid deliberately ignored for this one cycle
                DONE: begin
                    hdr_done <= 1'b0;
                    state    <= IDLE;
                end

                ERROR: begin
                    if (!in_valid) begin
                        hdr_err  <= 1'b0;
                        hdr_done <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_header_parse.sv
// Directed bench for bmp_header_parse: builds small BMP files in a byte
// queue, streams them in and compares forwarded bytes, pulses and header
// readouts against values derived here.
module tb_bmp_header_parse;

    localparam int unsigned BW = 8;
    localparam int unsigned DW = 16;

`ifdef BMP_PAD_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    // Hand-computed forwarded byte counts per image geometry
    localparam int N22 = STRIP ? 12 : 16;  // 2x2: row 8, pad 2
    localparam int N11 = STRIP ? 3  : 4;   // 1x1: row 4, pad 1
    localparam int N31 = STRIP ? 9  : 12;  // 3x1: row 12, pad 3

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          hdr_done;
    logic [DW-1:0] img_width;
    logic [DW-1:0] img_height;
    logic [15:0]   bpp;
    logic [31:0]   data_offset;
    logic          hdr_err;
    logic          frame_done;

    bmp_header_parse #(
        .BYTE_WIDTH(BW),
        .HDR_SIZE  (54),
        .DIM_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .hdr_done   (hdr_done),
        .img_width  (img_width),
        .img_height (img_height),
        .bpp        (bpp),
        .data_offset(data_offset),
        .hdr_err    (hdr_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  file_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] hw_q[$];
    logic [31:0] hh_q[$];
    logic [31:0] hb_q[$];
    logic [31:0] ho_q[$];
    int          fd_cnt = 0;
    logic        hdr_done_d = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (out_valid) got_q.push_back(out_data);
        if (frame_done) fd_cnt++;
        if (hdr_done && !hdr_done_d) begin
            hw_q.push_back(32'(img_width));
            hh_q.push_back(32'(img_height));
            hb_q.push_back(32'(bpp));
            ho_q.push_back(data_offset);
        end
        hdr_done_d <= hdr_done;
    end

    task automatic clear_all();
        file_q.delete();
        exp_q.delete();
        got_q.delete();
        hw_q.delete();
        hh_q.delete();
        hb_q.delete();
        ho_q.delete();
        fd_cnt = 0;
    endtask

    // Append one BMP file to file_q and its expected forwarded bytes to exp_q
    task automatic add_file(input int w, input int h, input int off, input int bits, input logic [7:0] sig1);
        int          row;
        int          len;
        logic [31:0] w32;
        logic [31:0] h32;
        logic [31:0] o32;
        logic [31:0] b32;
        logic [31:0] f32;
        logic [31:0] dib;
        logic [7:0]  v;
        row = ((w * 3 + 3) / 4) * 4;
        len = off + row * h;
        w32 = 32'(w);
        h32 = 32'(h);
        o32 = 32'(off);
        b32 = 32'(bits);
        f32 = 32'(len);
        dib = 32'd40;
        for (int i = 0; i < len; i++) begin
            if (i == 0)                v = 8'h42;
            else if (i == 1)           v = sig1;
            else if (i >= 2 && i < 6)  v = f32[8*(i-2) +: 8];
            else if (i >= 10 && i < 14) v = o32[8*(i-10) +: 8];
            else if (i >= 14 && i < 18) v = dib[8*(i-14) +: 8];
            else if (i >= 18 && i < 22) v = w32[8*(i-18) +: 8];
            else if (i >= 22 && i < 26) v = h32[8*(i-22) +: 8];
            else if (i == 26)          v = 8'd1;
            else if (i >= 28 && i < 30) v = b32[8*(i-28) +: 8];
            else if (i >= 54)          v = 8'(i * 13 + 5);
            else                       v = 8'h00;
            file_q.push_back(v);
            if (i >= off) begin
                if (!STRIP || (((i - off) % row) < w * 3)) exp_q.push_back(v);
            end
        end
    endtask

    // Drive file_q[lo..hi]; gap inserts an idle cycle after every byte
    task automatic send_range(input int lo, input int hi, input bit gap);
        for (int i = lo; i <= hi; i++) begin
            in_valid = 1'b1;
            in_data  = file_q[i];
            @(posedge clk); #1;
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = '0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic compare_stream(input string tag, input int n_exp);
        check({tag, "_count"}, 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic check_hdr(input string tag, input int idx, input int w, input int h, input int off);
        check({tag, "_hdr_seen"}, 32'(hw_q.size() > idx), 32'd1);
        if (hw_q.size() > idx) begin
            check({tag, "_width"},  hw_q[idx], 32'(w));
            check({tag, "_height"}, hh_q[idx], 32'(h));
            check({tag, "_bpp"},    hb_q[idx], 32'd24);
            check({tag, "_offset"}, ho_q[idx], 32'(off));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_data"},   32'(out_data),   32'd0);
        check({tag, "_hdr_done"},   32'(hdr_done),   32'd0);
        check({tag, "_hdr_err"},    32'(hdr_err),    32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_img_width"},  32'(img_width),  32'd0);
        check({tag, "_img_height"}, 32'(img_height), 32'd0);
        check({tag, "_bpp"},        32'(bpp),        32'd0);
        check({tag, "_data_offset"}, data_offset,    32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous 2x2, offset 54, 70-byte file
        clear_all();
        add_file(2, 2, 54, 24, 8'h4D);
        send_range(0, 69, 1'b0);
        idle(5);
        compare_stream("cont", N22);
        check("cont_frame_done", 32'(fd_cnt), 32'd1);
        check_hdr("cont", 0, 2, 2, 54);
        check("cont_hdr_done_cleared", 32'(hdr_done), 32'd0);

        // Bad signature: error one cycle after byte 29
        clear_all();
        add_file(2, 2, 54, 24, 8'h58);
        send_range(0, 28, 1'b0);
        check("err_before29", 32'(hdr_err), 32'd0);
        send_range(29, 29, 1'b0);
        check("err_after29", 32'(hdr_err), 32'd1);
        send_range(30, 45, 1'b0);
        check("err_held", 32'(hdr_err), 32'd1);
        idle(1);
        check("err_cleared", 32'(hdr_err), 32'd0);
        idle(3);
        check("err_no_output", 32'(got_q.size()), 32'd0);
        check("err_no_frame_done", 32'(fd_cnt), 32'd0);

        // 1x1 with offset 58: four gap bytes skipped
        clear_all();
        add_file(1, 1, 58, 24, 8'h4D);
        send_range(0, 61, 1'b0);
        idle(5);
        compare_stream("skip", N11);
        if (got_q.size() > 0) check("skip_first_byte", 32'(got_q[0]), 32'(file_q[58]));
        check("skip_frame_done", 32'(fd_cnt), 32'd1);
        check_hdr("skip", 0, 1, 1, 58);

        // Same 2x2 stream with in_valid low on alternate cycles
        clear_all();
        add_file(2, 2, 54, 24, 8'h4D);
        send_range(0, 69, 1'b1);
        idle(5);
        compare_stream("gap", N22);
        check("gap_frame_done", 32'(fd_cnt), 32'd1);

        // Reset after three pixel bytes, then a fresh 2x2 frame
        clear_all();
        add_file(2, 2, 54, 24, 8'h4D);
        send_range(0, 56, 1'b0);
        check("mid_out_valid_pre", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_reset_outputs("mid");
        @(posedge clk); #1;
        check_reset_outputs("mid_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_all();
        add_file(2, 2, 54, 24, 8'h4D);
        send_range(0, 69, 1'b0);
        idle(5);
        compare_stream("rst2", N22);
        check("rst2_frame_done", 32'(fd_cnt), 32'd1);
        check_hdr("rst2", 0, 2, 2, 54);

        // Back-to-back frames; a junk byte lands on the DONE cycle
        clear_all();
        add_file(2, 2, 54, 24, 8'h4D);
        file_q.push_back(8'hEE);
        add_file(3, 1, 54, 24, 8'h4D);
        send_range(0, file_q.size() - 1, 1'b0);
        idle(5);
        compare_stream("b2b", N22 + N31);
        check("b2b_frame_done", 32'(fd_cnt), 32'd2);
        check_hdr("b2b0", 0, 2, 2, 54);
        check_hdr("b2b1", 1, 3, 1, 54);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
